cdc_hs_sender: RTL

//   Source-domain (clk_a) end of a req/ack CDC handshake. Accepts one word per
//   vld/rdy transfer and holds it stable on data_out while req_out is raised.

---
 rtl/cdc_hs_sender.sv | 99 +++++++++
 1 files changed

// File: rtl/cdc_hs_sender.sv
// Source-domain end of a req/ack CDC handshake: one word per vld/rdy transfer, held on data_out while req_out is raised.
// Define CDC_HS_TWO_PHASE_EN for the two-phase toggle protocol; the default build is the four-phase level protocol.
module cdc_hs_sender #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2   // must be >= 2
) (
  input  logic              clk_a,
  input  logic              rst_n_a,
  input  logic              vld_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              rdy_out,
  output logic              req_out,
  output logic [DATA_W-1:0] data_out,
  input  logic              ack_in,
  output logic              xfer_done
);

`ifdef CDC_HS_TWO_PHASE_EN
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
`else
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ_HI = 2'd1;
  localparam logic [1:0] ST_REQ_LO = 2'd2;
`endif

  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic [1:0]             state;
  logic                   accept;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_a) begin
    if (!rst_n_a) ack_sync <= '0;
    else          ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_in};
  end

  assign ack_s = ack_sync[SYNC_STAGES-1];

`ifdef CDC_HS_TWO_PHASE_EN
  // Handshake is idle whenever the returned toggle matches the last one sent.
  assign rdy_out = (state == ST_IDLE) && (ack_s == req_out);
`else
  // A stale ack blocks acceptance until the far side has dropped it.
  assign rdy_out = (state == ST_IDLE) && !ack_s;
`endif

  assign accept = vld_in && rdy_out;

  always_ff @(posedge clk_a) begin
    if (!rst_n_a) begin
      state     <= ST_IDLE;
      req_out   <= 1'b0;
      data_out  <= '0;
      xfer_done <= 1'b0;
    end else begin
      xfer_done <= 1'b0;
      case (state)
`ifdef CDC_HS_TWO_PHASE_EN
        ST_IDLE: begin
          if (accept) begin
            data_out <= data_in;
            req_out  <= ~req_out;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (ack_s == req_out) begin
            xfer_done <= 1'b1;
            state     <= ST_IDLE;
          end
        end
`else
        ST_IDLE: begin
          if (accept) begin
            data_out <= data_in;
            req_out  <= 1'b1;
            state    <= ST_REQ_HI;
          end
        end
        ST_REQ_HI: begin
          if (ack_s) begin
            req_out <= 1'b0;
            state   <= ST_REQ_LO;
          end
        end
        ST_REQ_LO: begin
          if (!ack_s) begin
            xfer_done <= 1'b1;
            state     <= ST_IDLE;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
